// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver with frame-aligned double buffering
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int DIGITS        = 8,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int ZERO_SUPPRESS = 1
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_bcd_valid,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [DIGITS-1:0]     i_dp_mask,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     i_blink_mask,
`endif
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame_done,
  output logic                  o_have_data
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] DIG_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {S_BLANK, S_ON} state_t;
  localparam state_t S_RESET = (BLANK_CYCLES > 0) ? S_BLANK : S_ON;

  logic [CW-1:0]          slot_cnt, slot_next;
  logic [IW-1:0]          digit_idx;
  logic                   slot_wrap, boundary;
  state_t                 state, state_next;

  logic [4*DIGITS-1:0]    pend_bcd, disp_bcd;
  logic [DIGITS-1:0]      pend_dp, disp_dp;
  logic                   pend_flag;

  logic [DIGITS-1:0]      visible;
  logic                   any_nz;
  logic [3:0]             cur_nib;
  logic                   cur_dp, cur_vis, cur_blink;
  logic [6:0]             seg_d;
  logic                   dp_d;
  logic [DIGITS-1:0]      an_d;
  logic [DIGITS-1:0]      disp_blink;
  logic                   blink_phase;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    case (nib)
      4'd0: encode = 7'h40;
      4'd1: encode = 7'h79;
      4'd2: encode = 7'h24;
      4'd3: encode = 7'h30;
      4'd4: encode = 7'h19;
      4'd5: encode = 7'h12;
      4'd6: encode = 7'h02;
      4'd7: encode = 7'h78;
      4'd8: encode = 7'h00;
      4'd9: encode = 7'h10;
      default: encode = 7'h7F;
    endcase
  endfunction

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign boundary  = slot_wrap && (digit_idx == DIG_LAST);
  assign slot_next = slot_wrap ? '0 : slot_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_next;
      if (slot_wrap)
        digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  // A valid arriving on the boundary edge goes straight to display so it is not held for a whole frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_bcd    <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
      disp_bcd    <= '0;
      disp_dp     <= '0;
      o_have_data <= 1'b0;
    end else if (boundary && i_bcd_valid) begin
      disp_bcd    <= i_bcd;
      disp_dp     <= i_dp_mask;
      pend_flag   <= 1'b0;
      o_have_data <= 1'b1;
    end else if (boundary && pend_flag) begin
      disp_bcd    <= pend_bcd;
      disp_dp     <= pend_dp;
      pend_flag   <= 1'b0;
      o_have_data <= 1'b1;
    end else if (i_bcd_valid) begin
      pend_bcd  <= i_bcd;
      pend_dp   <= i_dp_mask;
      pend_flag <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  logic [DIGITS-1:0] pend_blink;
  logic [FW-1:0]     frame_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_blink <= '0;
      disp_blink <= '0;
    end else if (boundary && i_bcd_valid) begin
      disp_blink <= i_blink_mask;
    end else if (boundary && pend_flag) begin
      disp_blink <= pend_blink;
    end else if (i_bcd_valid) begin
      pend_blink <= i_blink_mask;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign disp_blink  = '0;
  assign blink_phase = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_RESET;
    else         state <= state_next;
  end

  // State tracks the slot counter, so look ahead at the counter's next value.
  always_comb begin
    state_next = S_ON;
    if (BLANK_CYCLES > 0 && slot_next < BLANK_END)
      state_next = S_BLANK;
  end

  always_comb begin
    any_nz  = 1'b0;
    visible = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz     = any_nz | (disp_bcd[4*i +: 4] != 4'd0);
      visible[i] = any_nz || (i == 0) || (ZERO_SUPPRESS == 0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_vis   = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nib   = disp_bcd[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_vis   = visible[i];
        cur_blink = disp_blink[i] & blink_phase;
      end
    end
  end

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (state == S_ON && o_have_data) begin
      for (int i = 0; i < DIGITS; i++)
        an_d[i] = (digit_idx != IW'(i));
      if (!cur_blink) begin
        seg_d = cur_vis ? encode(cur_nib) : 7'h7F;
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_seg        <= 7'h7F;
      o_dp         <= 1'b1;
      o_an         <= '1;
      o_frame_done <= 1'b0;
    end else begin
      o_seg        <= seg_d;
      o_dp         <= dp_d;
      o_an         <= an_d;
      o_frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// Compares every cycle against a frame-arithmetic model, plus table vectors and corner sequences.
module tb_seg7_scan_driver;
  localparam int D  = 8;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = RD * D;

  logic        clk = 1'b0;
  logic        rstn;
  logic        bcd_valid;
  logic [31:0] bcd;
  logic [7:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;
  logic        have_data;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ZERO_SUPPRESS(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_bcd_valid(bcd_valid), .i_bcd(bcd), .i_dp_mask(dp_mask),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_frame_done(frame_done), .o_have_data(have_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  int          n;
  logic [31:0] m_pend, m_disp;
  logic [7:0]  m_pdp, m_ddp;
  bit          m_pflag, m_have;
  int          obs_slot, obs_dig;
  bit          last_fd;
  logic [6:0]  enc_tab [16];

  localparam logic [17:0] RESET_VEC = {7'h7F, 1'b1, 8'hFF, 1'b0, 1'b0};

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dpm;
    int          dig;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [16:0] model_out(input int cyc);
    int slot, dig;
    logic [6:0] s;
    logic p;
    logic [7:0] a;
    slot = cyc % RD;
    dig  = (cyc / RD) % D;
    s = 7'h7F; p = 1'b1; a = 8'hFF;
    if (m_have && slot >= BL) begin
      a = ~(8'd1 << dig);
      if (dig == 0 || (m_disp >> (4 * dig)) != 0) s = enc_tab[m_disp[4*dig +: 4]];
      p = ~m_ddp[dig];
    end
    return {s, p, a, (cyc % FR) == FR - 1};
  endfunction

  task automatic step(input logic v, input logic [31:0] b, input logic [7:0] d);
    logic [17:0] exp;
    bit bnd;
    bcd_valid = v; bcd = b; dp_mask = d;
    exp[17:1] = model_out(n);
    bnd = (n % FR) == FR - 1;
    if (bnd && v) begin
      m_disp = b; m_ddp = d; m_pflag = 0; m_have = 1;
    end else if (bnd && m_pflag) begin
      m_disp = m_pend; m_ddp = m_pdp; m_pflag = 0; m_have = 1;
    end else if (v) begin
      m_pend = b; m_pdp = d; m_pflag = 1;
    end
    exp[0] = m_have;
    obs_slot = n % RD;
    obs_dig  = (n / RD) % D;
    last_fd  = bnd;
    n++;
    @(posedge clk); #1;
    chk("cycle", {14'd0, seg, dp, an, frame_done, have_data}, {14'd0, exp});
    bcd_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'd0, 8'd0);
  endtask

  task automatic run_to(input int dig, input int slot);
    int k;
    k = 0;
    do begin
      step(1'b0, 32'd0, 8'd0);
      k++;
    end while (!(obs_dig == dig && obs_slot == slot) && k < 200);
    if (k >= 200) chk("run_to_timeout", 32'(k), 32'd0);
  endtask

  task automatic wait_promote();
    int k;
    k = 0;
    while (!last_fd && k < 200) begin
      step(1'b0, 32'd0, 8'd0);
      k++;
    end
    if (k >= 200) chk("promote_timeout", 32'(k), 32'd0);
  endtask

  task automatic model_reset();
    n = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pflag = 0; m_have = 0;
    obs_slot = 0; obs_dig = 0; last_fd = 0;
  endtask

  task automatic apply_reset(input string name);
    rstn = 1'b0;
    #1;
    chk(name, {14'd0, seg, dp, an, frame_done, have_data}, {14'd0, RESET_VEC});
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] cur_bcd;
    logic [7:0]  cur_dpm;
    int fd_cnt;
    int k;
    logic [31:0] rb;

    enc_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[0]  = '{32'h0000_1234, 8'h00, 0, 7'h19, 1'b1, 8'hFE};
    vecs[1]  = '{32'h0000_1234, 8'h00, 1, 7'h30, 1'b1, 8'hFD};
    vecs[2]  = '{32'h0000_1234, 8'h00, 2, 7'h24, 1'b1, 8'hFB};
    vecs[3]  = '{32'h0000_1234, 8'h00, 3, 7'h79, 1'b1, 8'hF7};
    vecs[4]  = '{32'h0000_1234, 8'h00, 4, 7'h7F, 1'b1, 8'hEF};
    vecs[5]  = '{32'h0000_1234, 8'h00, 7, 7'h7F, 1'b1, 8'h7F};
    vecs[6]  = '{32'h0000_000A, 8'h01, 0, 7'h7F, 1'b0, 8'hFE};
    vecs[7]  = '{32'h0000_000A, 8'h01, 1, 7'h7F, 1'b1, 8'hFD};
    vecs[8]  = '{32'h8000_0000, 8'h80, 7, 7'h00, 1'b0, 8'h7F};
    vecs[9]  = '{32'h8000_0000, 8'h80, 0, 7'h40, 1'b1, 8'hFE};
    vecs[10] = '{32'h8000_0000, 8'h80, 3, 7'h40, 1'b1, 8'hF7};
    vecs[11] = '{32'h0000_0000, 8'h00, 0, 7'h40, 1'b1, 8'hFE};
    vecs[12] = '{32'h0000_0000, 8'h00, 1, 7'h7F, 1'b1, 8'hFD};
    vecs[13] = '{32'h9876_5432, 8'h00, 6, 7'h00, 1'b1, 8'hBF};
    vecs[14] = '{32'h9876_5432, 8'h00, 5, 7'h78, 1'b1, 8'hDF};
    vecs[15] = '{32'h9876_5432, 8'h04, 2, 7'h19, 1'b0, 8'hFB};

    bcd_valid = 1'b0; bcd = '0; dp_mask = '0;
    model_reset();
    rstn = 1'b0;
    #12;
    apply_reset("reset_state");

    fd_cnt = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      step(1'b0, 32'd0, 8'd0);
      if (frame_done) fd_cnt++;
    end
    chk("frame_done_count_3_frames", 32'(fd_cnt), 32'd3);

    cur_bcd = 32'hFFFF_FFFF;
    cur_dpm = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].bcd != cur_bcd || vecs[i].dpm != cur_dpm) begin
        idle(5);
        step(1'b1, vecs[i].bcd, vecs[i].dpm);
        wait_promote();
        cur_bcd = vecs[i].bcd;
        cur_dpm = vecs[i].dpm;
      end
      run_to(vecs[i].dig, 4);
      chk($sformatf("vec%0d_seg", i), {25'd0, seg}, {25'd0, vecs[i].seg});
      chk($sformatf("vec%0d_dp", i),  {31'd0, dp},  {31'd0, vecs[i].dp});
      chk($sformatf("vec%0d_an", i),  {24'd0, an},  {24'd0, vecs[i].an});
    end

    // Last valid before the boundary wins.
    k = 0;
    while ((n % FR) != 5 && k < 100) begin step(1'b0, 32'd0, 8'd0); k++; end
    step(1'b1, 32'h5, 8'h00);
    idle(10);
    step(1'b1, 32'h9, 8'h00);
    wait_promote();
    run_to(0, 4);
    chk("last_valid_wins_seg", {25'd0, seg}, 32'h10);

    // Valid on the boundary cycle shows in the very next digit-0 slot.
    k = 0;
    while ((n % FR) != FR - 1 && k < 100) begin step(1'b0, 32'd0, 8'd0); k++; end
    step(1'b1, 32'h7, 8'h00);
    chk("boundary_valid_fd", {31'd0, last_fd}, 32'd1);
    k = 0;
    do begin step(1'b0, 32'd0, 8'd0); k++; end while (!(obs_dig == 0 && obs_slot == 2) && k < 10);
    chk("boundary_valid_latency", 32'(k), 32'd3);
    chk("boundary_valid_seg", {25'd0, seg}, 32'h78);
    idle(FR - 8);
    run_to(0, 2);
    chk("boundary_next_frame_seg", {25'd0, seg}, 32'h78);

    for (int i = 0; i < 2000; i++) begin
      rb = $urandom >> (4 * $urandom_range(0, 7));
      step(($urandom % 30) == 0, rb, 8'($urandom));
    end

    // Reset mid-slot of digit 3, then nothing shows until a new value is promoted.
    run_to(3, 4);
    apply_reset("reset_mid_frame");
    idle(FR + 4);
    chk("no_data_after_reset", {31'd0, have_data}, 32'd0);
    step(1'b1, 32'h42, 8'h00);
    wait_promote();
    run_to(1, 3);
    chk("reload_after_reset_seg", {25'd0, seg}, 32'h19);
    chk("reload_after_reset_have", {31'd0, have_data}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
